// File: rtl/bp_stat_ctrl.sv
// bp_stat_ctrl: measurement-window controller for branch-predictor runs.
// Opens a counting window on start_i, counts RUN cycles, resolved branches
// and mispredictions with saturating counters, then holds a frozen snapshot
// until the consumer accepts it through a valid/ready handshake.
module bp_stat_ctrl #(
   parameter int unsigned CNT_W      = 32,
   parameter int unsigned WIN_CYCLES = 0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic             br_instr_i,
   input  logic             br_miss_i,
   input  logic             rd_ready_i,
   output logic             rd_valid_o,
   output logic             busy_o,
   output logic             ovf_o,
   output logic [CNT_W-1:0] cyc_cnt_o,
   output logic [CNT_W-1:0] br_cnt_o,
   output logic [CNT_W-1:0] miss_cnt_o
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_HOLD
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WIN_CYCLES - 32'd1);
   localparam bit               WIN_EN   = (WIN_CYCLES != 0);

   state_t state;

   logic cyc_sat;
   logic br_sat;
   logic miss_sat;
   logic miss_evt;
   logic win_done;
   logic ovf_hit;

   // Saturation flags, window-end detection and overflow events for this RUN cycle
   always_comb begin
      cyc_sat  = (cyc_cnt_o == CNT_MAX);
      br_sat   = (br_cnt_o == CNT_MAX);
      miss_sat = (miss_cnt_o == CNT_MAX);
      miss_evt = br_instr_i & br_miss_i;
      win_done = WIN_EN && (cyc_cnt_o == WIN_LAST);
      ovf_hit  = cyc_sat | (br_instr_i & br_sat) | (miss_evt & miss_sat);
   end

   // Window FSM with registered status outputs and saturating counters
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state      <= ST_IDLE;
         rd_valid_o <= 1'b0;
         busy_o     <= 1'b0;
         ovf_o      <= 1'b0;
         cyc_cnt_o  <= '0;
         br_cnt_o   <= '0;
         miss_cnt_o <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start_i) begin
                  state      <= ST_RUN;
                  busy_o     <= 1'b1;
                  ovf_o      <= 1'b0;
                  cyc_cnt_o  <= '0;
                  br_cnt_o   <= '0;
                  miss_cnt_o <= '0;
               end
            end
            ST_RUN: begin
               if (!cyc_sat) cyc_cnt_o <= cyc_cnt_o + 1'b1;
               if (br_instr_i && !br_sat) br_cnt_o <= br_cnt_o + 1'b1;
               if (miss_evt && !miss_sat) miss_cnt_o <= miss_cnt_o + 1'b1;
               if (ovf_hit) ovf_o <= 1'b1;
               if (stop_i || win_done) begin
                  state      <= ST_HOLD;
                  busy_o     <= 1'b0;
                  rd_valid_o <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (rd_ready_i) begin
                  state      <= ST_IDLE;
                  rd_valid_o <= 1'b0;
               end
            end
            default: begin
               state      <= ST_IDLE;
               busy_o     <= 1'b0;
               rd_valid_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bp_stat_ctrl.sv
// tb_bp_stat_ctrl: drives three bp_stat_ctrl configurations from shared
// stimulus (free-running, 8-cycle window, 4-bit counters) and compares every
// output each cycle against a behavioural model of the measurement window.
module tb_bp_stat_ctrl;

   logic clk = 1'b0;
   logic rst_n, start, stop, br_instr, br_miss, rd_ready;

   logic        rv0, busy0, ovf0;
   logic [31:0] cyc0, br0, miss0;
   logic        rv1, busy1, ovf1;
   logic [31:0] cyc1, br1, miss1;
   logic        rv2, busy2, ovf2;
   logic [3:0]  cyc2, br2, miss2;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   bp_stat_ctrl #(.CNT_W(32), .WIN_CYCLES(0)) u_free (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop),
      .br_instr_i(br_instr), .br_miss_i(br_miss), .rd_ready_i(rd_ready),
      .rd_valid_o(rv0), .busy_o(busy0), .ovf_o(ovf0),
      .cyc_cnt_o(cyc0), .br_cnt_o(br0), .miss_cnt_o(miss0));

   bp_stat_ctrl #(.CNT_W(32), .WIN_CYCLES(8)) u_win (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop),
      .br_instr_i(br_instr), .br_miss_i(br_miss), .rd_ready_i(rd_ready),
      .rd_valid_o(rv1), .busy_o(busy1), .ovf_o(ovf1),
      .cyc_cnt_o(cyc1), .br_cnt_o(br1), .miss_cnt_o(miss1));

   bp_stat_ctrl #(.CNT_W(4), .WIN_CYCLES(0)) u_sat (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop),
      .br_instr_i(br_instr), .br_miss_i(br_miss), .rd_ready_i(rd_ready),
      .rd_valid_o(rv2), .busy_o(busy2), .ovf_o(ovf2),
      .cyc_cnt_o(cyc2), .br_cnt_o(br2), .miss_cnt_o(miss2));

   // Reference model: one entry per instance
   int unsigned       m_width [3] = '{32, 32, 4};
   int unsigned       m_win   [3] = '{0, 8, 0};
   bit                m_open  [3];
   bit                m_ready [3];
   bit                m_ovf   [3];
   longint unsigned   m_cyc   [3];
   longint unsigned   m_br    [3];
   longint unsigned   m_miss  [3];

   task automatic check_eq(input string tag, input longint unsigned obs,
                           input longint unsigned exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic longint unsigned cap(input int unsigned k);
      return (64'd1 << m_width[k]) - 64'd1;
   endfunction

   // Adds one event to a counter; an event that finds it full is lost and flagged
   task automatic bump(input int unsigned k, inout longint unsigned c);
      if (c >= cap(k)) m_ovf[k] = 1'b1;
      else c = c + 1;
   endtask

   task automatic model_edge(input int unsigned k);
      bit closing;
      if (!rst_n) begin
         m_open[k] = 0; m_ready[k] = 0; m_ovf[k] = 0;
         m_cyc[k] = 0; m_br[k] = 0; m_miss[k] = 0;
      end else if (m_ready[k]) begin
         if (rd_ready) m_ready[k] = 0;
      end else if (m_open[k]) begin
         closing = stop || (m_win[k] != 0 && m_cyc[k] + 1 == m_win[k]);
         bump(k, m_cyc[k]);
         if (br_instr) bump(k, m_br[k]);
         if (br_instr && br_miss) bump(k, m_miss[k]);
         if (closing) begin
            m_open[k] = 0; m_ready[k] = 1;
         end
      end else if (start) begin
         m_open[k] = 1; m_ovf[k] = 0;
         m_cyc[k] = 0; m_br[k] = 0; m_miss[k] = 0;
      end
   endtask

   task automatic check_inst(input int unsigned k, input string nm, input bit rv,
                             input bit busy, input bit ovf, input longint unsigned cyc,
                             input longint unsigned br, input longint unsigned miss);
      check_eq({nm, ".rd_valid"}, 64'(rv), 64'(m_ready[k]));
      check_eq({nm, ".busy"}, 64'(busy), 64'(m_open[k]));
      check_eq({nm, ".ovf"}, 64'(ovf), 64'(m_ovf[k]));
      check_eq({nm, ".cyc"}, cyc, m_cyc[k]);
      check_eq({nm, ".br"}, br, m_br[k]);
      check_eq({nm, ".miss"}, miss, m_miss[k]);
   endtask

   // One clock: apply inputs, advance the model at the edge, compare after it
   task automatic step(input bit rn, input bit st, input bit sp, input bit bi,
                       input bit bm, input bit rdy);
      rst_n = rn; start = st; stop = sp; br_instr = bi; br_miss = bm; rd_ready = rdy;
      @(posedge clk);
      for (int unsigned k = 0; k < 3; k++) model_edge(k);
      #1;
      check_inst(0, "free", rv0, busy0, ovf0, 64'(cyc0), 64'(br0), 64'(miss0));
      check_inst(1, "win", rv1, busy1, ovf1, 64'(cyc1), 64'(br1), 64'(miss1));
      check_inst(2, "sat", rv2, busy2, ovf2, 64'(cyc2), 64'(br2), 64'(miss2));
   endtask

   initial begin
      rst_n = 0; start = 0; stop = 0; br_instr = 0; br_miss = 0; rd_ready = 0;

      // Reset, idle, stray stop in IDLE
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0);
      step(1, 0, 1, 0, 0, 0);
      check_eq("idle.busy", 64'(busy0), 64'd0);
      check_eq("idle.rv", 64'(rv0), 64'd0);

      // 10-cycle window, 4 branches, 1 miss, stop on the 10th
      step(1, 1, 0, 0, 0, 0);
      check_eq("start.busy", 64'(busy0), 64'd1);
      for (int i = 1; i <= 10; i++)
         step(1, 0, i == 10, i == 2 || i == 4 || i == 7 || i == 10, i == 4, 0);
      check_eq("win10.cyc", 64'(cyc0), 64'd10);
      check_eq("win10.br", 64'(br0), 64'd4);
      check_eq("win10.miss", 64'(miss0), 64'd1);
      check_eq("win10.rv", 64'(rv0), 64'd1);

      // HOLD ignores start and stays until ready
      for (int i = 0; i < 3; i++) step(1, i == 1, 0, 1, 1, 0);
      check_eq("hold.cyc", 64'(cyc0), 64'd10);
      check_eq("hold.rv", 64'(rv0), 64'd1);
      step(1, 0, 0, 0, 0, 1);
      check_eq("ack.rv", 64'(rv0), 64'd0);
      check_eq("ack.cyc_kept", 64'(cyc0), 64'd10);

      // Auto-stop after 8 cycles
      step(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) step(1, 0, 0, 1, 0, 0);
      check_eq("auto.cyc", 64'(cyc1), 64'd8);
      check_eq("auto.br", 64'(br1), 64'd8);
      check_eq("auto.busy", 64'(busy1), 64'd0);
      check_eq("auto.rv", 64'(rv1), 64'd1);
      step(1, 0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 1);

      // 4-bit saturation, then a fresh start clears it
      step(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0, 0);
      check_eq("sat.cyc", 64'(cyc2), 64'd15);
      check_eq("sat.ovf", 64'(ovf2), 64'd1);
      step(1, 0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 1);
      check_eq("sat.ovf_idle", 64'(ovf2), 64'd1);
      step(1, 1, 0, 0, 0, 0);
      check_eq("restart.cyc", 64'(cyc2), 64'd0);
      check_eq("restart.ovf", 64'(ovf2), 64'd0);
      step(1, 0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 1);

      // Unqualified misses, then reset mid-RUN
      step(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 1, 0);
      check_eq("miss_only.cyc", 64'(cyc0), 64'd6);
      check_eq("miss_only.miss", 64'(miss0), 64'd0);
      step(0, 0, 0, 1, 1, 0);
      check_eq("rst.busy", 64'(busy0), 64'd0);
      check_eq("rst.cyc", 64'(cyc0), 64'd0);

      // Randomized traffic
      for (int i = 0; i < 4000; i++)
         step($urandom_range(0, 199) != 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 11) == 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
